// File: rtl/register_file_param.sv
// register_file_param: parametrised integer register file for the RISC-V datapath.
//   Two registered read ports, one write port, optional write-to-read bypass,
//   optional hardwired zero entry. After reset a sweep clears (or index-seeds)
//   one entry per cycle so storage needs no per-entry reset; ready flags the end.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active-low
//   RegWrite   write enable
//   RD         write address
//   WriteData  write data
//   RS1, RS2   read addresses
//   ReadData1/2 registered read data (latency 1)
//   ready      1 once the clear sweep has finished
//   clear_idx  sweep pointer (debug)
module register_file_param #(
  parameter int XLEN       = 64,
  parameter int NREGS      = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  parameter int INIT_INDEX = 1,
  localparam int AW        = (NREGS > 2) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWrite,
  input  logic [AW-1:0]   RD,
  input  logic [XLEN-1:0] WriteData,
  input  logic [AW-1:0]   RS1,
  input  logic [AW-1:0]   RS2,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  output logic            ready,
  output logic [AW-1:0]   clear_idx
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // One extra bit so NREGS itself is representable for range checks.
  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [XLEN-1:0] regs [NREGS];

  state_e          state_q, state_d;
  logic [AW-1:0]   clear_idx_q, clear_idx_d;
  logic [XLEN-1:0] rdata1_q, rdata1_d;
  logic [XLEN-1:0] rdata2_q, rdata2_d;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  logic            wr_ok;
  logic            rs1_valid, rs2_valid;

  always_comb begin
    wr_ok     = (state_q == READY) && RegWrite && ({1'b0, RD} < NREGS_W)
                && !((ZERO_REG != 0) && (RD == '0));
    rs1_valid = ({1'b0, RS1} < NREGS_W) && !((ZERO_REG != 0) && (RS1 == '0));
    rs2_valid = ({1'b0, RS2} < NREGS_W) && !((ZERO_REG != 0) && (RS2 == '0));
  end

  // Next state, sweep pointer and storage write port.
  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    mem_we      = 1'b0;
    mem_waddr   = RD;
    mem_wdata   = WriteData;
    unique case (state_q)
      CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clear_idx_q;
        mem_wdata   = (INIT_INDEX != 0) ? XLEN'(clear_idx_q) : '0;
        clear_idx_d = clear_idx_q + 1'b1;
        if (clear_idx_q == LAST_IDX) state_d = READY;
      end
      READY: begin
        mem_we = wr_ok;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Read ports: forwarding is decided here, before the storage update lands.
  always_comb begin
    rdata1_d = '0;
    rdata2_d = '0;
    if (state_q == READY) begin
      if (rs1_valid) begin
        rdata1_d = ((BYPASS != 0) && wr_ok && (RD == RS1)) ? WriteData : regs[RS1];
      end
      if (rs2_valid) begin
        rdata2_d = ((BYPASS != 0) && wr_ok && (RD == RS2)) ? WriteData : regs[RS2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CLEAR;
      clear_idx_q <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
    end
  end

  // Storage has no reset so it can map onto RAM; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) regs[mem_waddr] <= mem_wdata;
  end

  assign ReadData1 = rdata1_q;
  assign ReadData2 = rdata2_q;
  assign ready     = (state_q == READY);
  assign clear_idx = clear_idx_q;

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: two instances share stimulus.
//   dut_a: NREGS=32, ZERO_REG=1, BYPASS=1, INIT_INDEX=1
//   dut_b: NREGS=24, ZERO_REG=0, BYPASS=0, INIT_INDEX=1
// Expected outputs come from a behavioural model, queued at drive time and
// popped after the edge.
module tb_register_file_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [63:0] WriteData;
  logic [4:0]  RS1, RS2;

  logic [63:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_rdy, b_rdy;
  logic [4:0]  a_idx, b_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_file_param #(.XLEN(64), .NREGS(32), .ZERO_REG(1), .BYPASS(1), .INIT_INDEX(1)) dut_a (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
    .RS1(RS1), .RS2(RS2), .ReadData1(a_rd1), .ReadData2(a_rd2), .ready(a_rdy), .clear_idx(a_idx)
  );

  register_file_param #(.XLEN(64), .NREGS(24), .ZERO_REG(0), .BYPASS(0), .INIT_INDEX(1)) dut_b (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
    .RS1(RS1), .RS2(RS2), .ReadData1(b_rd1), .ReadData2(b_rd2), .ready(b_rdy), .clear_idx(b_idx)
  );

  typedef struct {
    logic [63:0] a1, a2, b1, b2;
    logic        ra, rb;
    logic [4:0]  ia, ib;
    logic        cia, cib;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model, index 0 = dut_a, 1 = dut_b.
  logic [63:0] m_mem [2][32];
  logic        m_rdy [2];
  logic [4:0]  m_idx [2];

  function automatic int nr(input int k);
    return (k == 0) ? 32 : 24;
  endfunction
  function automatic bit zr(input int k);
    return k == 0;
  endfunction
  function automatic bit bp(input int k);
    return k == 0;
  endfunction

  function automatic logic [63:0] mread(input int k, input logic [4:0] ra, input logic wok);
    if (int'(ra) >= nr(k) || (zr(k) && ra == 5'd0)) return 64'd0;
    if (bp(k) && wok && RD == ra) return WriteData;
    return m_mem[k][ra];
  endfunction

  task automatic model_step(input int k, output logic [63:0] o1, output logic [63:0] o2);
    logic wok;
    if (!m_rdy[k]) begin
      m_mem[k][m_idx[k]] = {59'd0, m_idx[k]};
      if (int'(m_idx[k]) == nr(k) - 1) m_rdy[k] = 1'b1;
      m_idx[k] = m_idx[k] + 5'd1;
      o1 = 64'd0;
      o2 = 64'd0;
    end else begin
      wok = RegWrite && (int'(RD) < nr(k)) && !(zr(k) && RD == 5'd0);
      o1 = mread(k, RS1, wok);
      o2 = mread(k, RS2, wok);
      if (wok) m_mem[k][RD] = WriteData;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, predict, advance past the edge, compare.
  task automatic tick(input logic we, input logic [4:0] rd, input logic [63:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    RegWrite = we; RD = rd; WriteData = wd; RS1 = r1; RS2 = r2;
    model_step(0, e.a1, e.a2);
    model_step(1, e.b1, e.b2);
    e.ra = m_rdy[0]; e.rb = m_rdy[1];
    e.ia = m_idx[0]; e.ib = m_idx[1];
    e.cia = !m_rdy[0]; e.cib = !m_rdy[1];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("a_rd1", a_rd1, e.a1);
      check("a_rd2", a_rd2, e.a2);
      check("b_rd1", b_rd1, e.b1);
      check("b_rd2", b_rd2, e.b2);
      check("a_ready", {63'd0, a_rdy}, {63'd0, e.ra});
      check("b_ready", {63'd0, b_rdy}, {63'd0, e.rb});
      if (e.cia) check("a_clear_idx", {59'd0, a_idx}, {59'd0, e.ia});
      if (e.cib) check("b_clear_idx", {59'd0, b_idx}, {59'd0, e.ib});
    end
  endtask

  // Assert reset away from an edge, check async clear, hold across one edge.
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check("rst_a_rd1", a_rd1, 64'd0);
    check("rst_a_rd2", a_rd2, 64'd0);
    check("rst_b_rd1", b_rd1, 64'd0);
    check("rst_a_ready", {63'd0, a_rdy}, 64'd0);
    check("rst_b_ready", {63'd0, b_rdy}, 64'd0);
    check("rst_a_idx", {59'd0, a_idx}, 64'd0);
    for (int k = 0; k < 2; k++) begin
      m_rdy[k] = 1'b0;
      m_idx[k] = 5'd0;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Sweep with writes attempted throughout; measure cycles until ready.
  task automatic sweep_and_count();
    int na = 0;
    int nb = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1, 5'd3, 64'hFF, 5'd5, 5'd31);
      if (nb == 0 && b_rdy) nb = i;
      if (na == 0 && a_rdy) begin
        na = i;
        break;
      end
    end
    check("a_sweep_len", 64'(na), 64'd32);
    check("b_sweep_len", 64'(nb), 64'd24);
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; RD = '0; WriteData = '0; RS1 = '0; RS2 = '0;
    #2;
    pulse_reset();

    // Sweep, with RD=3 writes that dut_a must ignore.
    sweep_and_count();

    tick(1'b0, 5'd0, 64'd0, 5'd5, 5'd31);
    check("t1_a_rs1_5", a_rd1, 64'd5);
    check("t1_a_rs2_31", a_rd2, 64'd31);

    tick(1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
    check("t5_a_entry3", a_rd1, 64'd3);

    tick(1'b1, 5'd0, 64'hDEAD, 5'd0, 5'd0);
    tick(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    check("t2_a_zero", a_rd1, 64'd0);
    check("t2_b_entry0", b_rd1, 64'hDEAD);

    tick(1'b1, 5'd7, 64'h1234, 5'd7, 5'd7);
    check("t3_a_bypass", a_rd1, 64'h1234);
    check("t3_b_old", b_rd1, 64'd7);
    tick(1'b0, 5'd0, 64'd0, 5'd7, 5'd7);
    check("t3_b_new", b_rd2, 64'h1234);

    tick(1'b1, 5'd30, 64'hCAFE, 5'd30, 5'd30);
    tick(1'b0, 5'd0, 64'd0, 5'd0, 5'd30);
    check("t6_b_oor", b_rd2, 64'd0);
    check("t6_a_30", a_rd2, 64'hCAFE);
    for (int j = 0; j < 24; j++) tick(1'b0, 5'd0, 64'd0, 5'(j), 5'(23 - j));

    for (int j = 0; j < 60; j++) begin
      tick(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           {32'($urandom), 32'($urandom)}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Reset while READY with nonzero read data held.
    tick(1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
    pulse_reset();

    // Mid-sweep reset at clear_idx=10 restarts the sweep.
    for (int j = 0; j < 10; j++) tick(1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    check("t4_idx10", {59'd0, a_idx}, 64'd10);
    pulse_reset();
    sweep_and_count();
    tick(1'b0, 5'd0, 64'd0, 5'd7, 5'd30);
    check("t4_a_reseeded7", a_rd1, 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
